// File: rtl/control_sequencer.sv
// Hardwired control unit for the multi-cycle CPU datapath: a fetch/execute
// sequencer whose strobes are a Moore decode of the current step, IR and CON.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZLowOut,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        RCout,
  output logic        CONin,
  output logic [4:0]  alu_op,
  output logic        Run
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_ADDI, C_LD, C_LDI, C_ST, C_BR, C_JR, C_HALT, C_NOP
  } cls_t;

  state_t      state_r;
  cls_t        cls_s;
  logic [4:0]  op_s;
  logic        ir_unused_s;

  assign op_s        = IR[31:27];
  assign ir_unused_s = &{1'b0, IR[26:0]};

  // Opcode classification; unlisted opcodes fall into the nop class.
  always_comb begin
    cls_s = C_NOP;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls_s = C_ALU;
      OP_ADDI:                       cls_s = C_ADDI;
      OP_LD:                         cls_s = C_LD;
      OP_LDI:                        cls_s = C_LDI;
      OP_ST:                         cls_s = C_ST;
      OP_BR:                         cls_s = C_BR;
      OP_JR:                         cls_s = C_JR;
      OP_HALT:                       cls_s = C_HALT;
      default:                       cls_s = C_NOP;
    endcase
  end

  // Step sequencing; IR is only consulted at the T3/T5/T6 branch points.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= ST_RESET;
    end else begin
      case (state_r)
        ST_RESET: state_r <= ST_T0;
        ST_T0:    state_r <= ST_T1;
        ST_T1:    state_r <= ST_T2;
        ST_T2:    state_r <= ST_T3;
        ST_T3: begin
          case (cls_s)
            C_HALT:      state_r <= ST_HALT;
            C_JR, C_NOP: state_r <= ST_T0;
            default:     state_r <= ST_T4;
          endcase
        end
        ST_T4:    state_r <= ST_T5;
        ST_T5:    state_r <= (cls_s == C_LD || cls_s == C_ST || cls_s == C_BR) ? ST_T6 : ST_T0;
        ST_T6:    state_r <= (cls_s == C_BR) ? ST_T0 : ST_T7;
        ST_T7:    state_r <= ST_T0;
        ST_HALT:  state_r <= ST_HALT;
        default:  state_r <= ST_RESET;
      endcase
    end
  end

  // Strobe decode; fetch steps ignore IR, so a changing IR there is harmless.
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin} = 10'd0;
    {ZLowIn, ZLowOut, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin} = 10'd0;
    alu_op = 5'b00000;
    Run    = (state_r != ST_RESET) && (state_r != ST_HALT);
    case (state_r)
      ST_T0: {PCout, MARin, IncPC} = 3'b111;
      ST_T1: {Read, MDRin}         = 2'b11;
      ST_T2: {MDRout, IRin}        = 2'b11;
      ST_T3: begin
        case (cls_s)
          C_ALU, C_ADDI:     {Grb, Rout, Yin}   = 3'b111;
          C_LD, C_LDI, C_ST: {Grb, BAout, Yin}  = 3'b111;
          C_BR:              {Gra, Rout, CONin} = 3'b111;
          C_JR:              {Gra, Rout, PCin}  = 3'b111;
          default:           Yin = 1'b0;
        endcase
      end
      ST_T4: begin
        case (cls_s)
          C_ALU: begin
            {Grc, Rout, ZLowIn} = 3'b111;
            alu_op = op_s;
          end
          C_ADDI, C_LD, C_LDI, C_ST: begin
            {RCout, ZLowIn} = 2'b11;
            alu_op = OP_ADD;
          end
          C_BR:    {PCout, Yin} = 2'b11;
          default: Yin = 1'b0;
        endcase
      end
      ST_T5: begin
        case (cls_s)
          C_ALU, C_ADDI, C_LDI: {ZLowOut, Gra, Rin} = 3'b111;
          C_LD, C_ST:           {ZLowOut, MARin}    = 2'b11;
          C_BR: begin
            {RCout, ZLowIn} = 2'b11;
            alu_op = OP_ADD;
          end
          default: Yin = 1'b0;
        endcase
      end
      ST_T6: begin
        case (cls_s)
          C_LD:    {Read, MDRin}      = 2'b11;
          C_ST:    {Gra, Rout, MDRin} = 3'b111;
          C_BR:    {ZLowOut, PCin}    = {1'b1, CON};
          default: Yin = 1'b0;
        endcase
      end
      ST_T7: begin
        case (cls_s)
          C_LD:    {MDRout, Gra, Rin} = 3'b111;
          C_ST:    Write = 1'b1;
          default: Yin = 1'b0;
        endcase
      end
      default: Yin = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected
// strobe vector per cycle, a negedge monitor pops and compares.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR    = 32'd0;
  logic        CON   = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic ZLowIn, ZLowOut, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin;
  logic [4:0] alu_op;
  logic       Run;

  int checks   = 0;
  int failures = 0;

  logic [25:0] exp_q[$];
  string       name_q[$];
  logic [25:0] obs_s;

  localparam logic [25:0] ZERO    = 26'd0;
  localparam logic [25:0] RUN     = 26'd1 << 25;
  localparam logic [25:0] PCOUT   = 26'd1 << 19;
  localparam logic [25:0] PCIN    = 26'd1 << 18;
  localparam logic [25:0] INCPC   = 26'd1 << 17;
  localparam logic [25:0] MARIN   = 26'd1 << 16;
  localparam logic [25:0] MDRIN   = 26'd1 << 15;
  localparam logic [25:0] MDROUT  = 26'd1 << 14;
  localparam logic [25:0] READ    = 26'd1 << 13;
  localparam logic [25:0] WRITE   = 26'd1 << 12;
  localparam logic [25:0] IRIN    = 26'd1 << 11;
  localparam logic [25:0] YIN     = 26'd1 << 10;
  localparam logic [25:0] ZLOWIN  = 26'd1 << 9;
  localparam logic [25:0] ZLOWOUT = 26'd1 << 8;
  localparam logic [25:0] GRA     = 26'd1 << 7;
  localparam logic [25:0] GRB     = 26'd1 << 6;
  localparam logic [25:0] GRC     = 26'd1 << 5;
  localparam logic [25:0] RIN     = 26'd1 << 4;
  localparam logic [25:0] ROUT    = 26'd1 << 3;
  localparam logic [25:0] BAOUT   = 26'd1 << 2;
  localparam logic [25:0] RCOUT   = 26'd1 << 1;
  localparam logic [25:0] CONIN   = 26'd1 << 0;
  localparam logic [25:0] ADD_OP  = {1'b0, 5'b00011, 20'd0};

  localparam logic [31:0] I_ADD  = 32'h18A18000;
  localparam logic [31:0] I_LD   = 32'h00000000;
  localparam logic [31:0] I_LDI  = 32'h08000000;
  localparam logic [31:0] I_ST   = 32'h10000000;
  localparam logic [31:0] I_SUB  = 32'h20000000;
  localparam logic [31:0] I_AND  = 32'h48000000;
  localparam logic [31:0] I_ADDI = 32'h58000000;
  localparam logic [31:0] I_BR   = 32'h90000000;
  localparam logic [31:0] I_JR   = 32'h98000000;
  localparam logic [31:0] I_HALT = 32'hD0000000;
  localparam logic [31:0] I_UNK  = 32'hF8000000;
  localparam logic [31:0] JUNK   = 32'hD7FFFFFF;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZLowOut(ZLowOut), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .RCout(RCout), .CONin(CONin),
    .alu_op(alu_op), .Run(Run)
  );

  always #5 clock = ~clock;

  assign obs_s = {Run, alu_op, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
                  IRin, Yin, ZLowIn, ZLowOut, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin};

  // Monitor: compare whatever the DUT presents against the oldest queued entry.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [25:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", n, obs_s, e);
      end
    end
  end

  task automatic cyc(input logic clr, input logic [31:0] ir, input logic con,
                     input logic [25:0] e, input string nm);
    @(posedge clock);
    #1;
    clear = clr;
    IR    = ir;
    CON   = con;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input logic [31:0] junk);
    cyc(1'b1, junk, 1'b0, RUN | PCOUT | MARIN | INCPC, "fetch_t0");
    cyc(1'b1, ~junk, 1'b1, RUN | READ | MDRIN, "fetch_t1");
    cyc(1'b1, junk, 1'b0, RUN | MDROUT | IRIN, "fetch_t2");
  endtask

  task automatic run_alu(input logic [31:0] ir, input string nm);
    fetch(JUNK);
    cyc(1'b1, ir, 1'b0, RUN | GRB | ROUT | YIN, {nm, "_t3"});
    cyc(1'b1, ir, 1'b0, RUN | GRC | ROUT | ZLOWIN | {1'b0, ir[31:27], 20'd0}, {nm, "_t4"});
    cyc(1'b1, ir, 1'b0, RUN | ZLOWOUT | GRA | RIN, {nm, "_t5"});
  endtask

  task automatic run_imm(input logic [31:0] ir, input logic [25:0] t3, input string nm);
    fetch(JUNK);
    cyc(1'b1, ir, 1'b0, t3, {nm, "_t3"});
    cyc(1'b1, ir, 1'b0, RUN | RCOUT | ZLOWIN | ADD_OP, {nm, "_t4"});
    cyc(1'b1, ir, 1'b0, RUN | ZLOWOUT | GRA | RIN, {nm, "_t5"});
  endtask

  task automatic run_mem_head(input logic [31:0] ir, input string nm);
    fetch(JUNK);
    cyc(1'b1, ir, 1'b0, RUN | GRB | BAOUT | YIN, {nm, "_t3"});
    cyc(1'b1, ir, 1'b0, RUN | RCOUT | ZLOWIN | ADD_OP, {nm, "_t4"});
    cyc(1'b1, ir, 1'b0, RUN | ZLOWOUT | MARIN, {nm, "_t5"});
  endtask

  task automatic run_br(input logic con, input string nm);
    fetch(JUNK);
    cyc(1'b1, I_BR, con, RUN | GRA | ROUT | CONIN, {nm, "_t3"});
    cyc(1'b1, I_BR, con, RUN | PCOUT | YIN, {nm, "_t4"});
    cyc(1'b1, I_BR, con, RUN | RCOUT | ZLOWIN | ADD_OP, {nm, "_t5"});
    cyc(1'b1, I_BR, con, RUN | ZLOWOUT | (con ? PCIN : ZERO), {nm, "_t6"});
  endtask

  initial begin
    // Power-up reset, then release.
    cyc(1'b0, JUNK, 1'b0, ZERO, "reset_hold0");
    cyc(1'b0, JUNK, 1'b0, ZERO, "reset_hold1");
    cyc(1'b1, JUNK, 1'b0, ZERO, "reset_release");

    run_alu(I_ADD, "add");
    run_mem_head(I_LD, "ld");
    cyc(1'b1, I_LD, 1'b0, RUN | READ | MDRIN, "ld_t6");
    cyc(1'b1, I_LD, 1'b0, RUN | MDROUT | GRA | RIN, "ld_t7");
    run_br(1'b1, "br_taken");
    run_br(1'b0, "br_not_taken");
    run_mem_head(I_ST, "st");
    cyc(1'b1, I_ST, 1'b0, RUN | GRA | ROUT | MDRIN, "st_t6");
    cyc(1'b1, I_ST, 1'b0, RUN | WRITE, "st_t7");
    run_alu(I_SUB, "sub");
    run_alu(I_AND, "and");
    run_imm(I_LDI, RUN | GRB | BAOUT | YIN, "ldi");
    run_imm(I_ADDI, RUN | GRB | ROUT | YIN, "addi");
    fetch(JUNK);
    cyc(1'b1, I_JR, 1'b0, RUN | GRA | ROUT | PCIN, "jr_t3");
    fetch(JUNK);
    cyc(1'b1, I_UNK, 1'b0, RUN, "unknown_t3");

    // Reset asserted in the middle of a load, held two cycles.
    run_mem_head(I_LD, "ld_rst");
    cyc(1'b0, I_LD, 1'b0, RUN | READ | MDRIN, "ld_rst_t6");
    cyc(1'b0, I_LD, 1'b0, ZERO, "mid_reset_hold");
    cyc(1'b1, I_LD, 1'b0, ZERO, "mid_reset_release");

    // Halt: parked until clear drops.
    fetch(I_LD);
    cyc(1'b1, I_HALT, 1'b0, RUN, "halt_t3");
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i % 2 == 0) ? JUNK : I_ADD, i[0], ZERO, "halt_idle");
    end
    cyc(1'b0, JUNK, 1'b0, ZERO, "halt_clear");
    cyc(1'b1, JUNK, 1'b0, ZERO, "halt_reset_release");
    fetch(JUNK);

    @(posedge clock);
    @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port clear, input, 1, synchronous active-low reset, sampled on rising edge of clock.
REQ-003 SHALL have port IR, input, 32, instruction register contents: opcode IR[31:27].
REQ-004 SHALL have port CON, input, 1, branch-condition flag from datapath CON flip-flop.
REQ-005 SHALL have outputs PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, ZLowIn, ZLowOut, Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin, each 1 bit, default 0, datapath strobes of the same names.
REQ-006 SHALL have port alu_op, output, 5, ALU operation code, default 5'b00000.
REQ-007 SHALL have port Run, output, 1, default 0, high while sequencing and low in RESET and HALT.

Function
REQ-008 SHALL be a Moore FSM with states RESET, T0–T7 and HALT; outputs decode from state, IR and CON only; one state per clock.
REQ-009 SHALL use opcodes ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=01001, or=01010, addi=01011, br=10010, jr=10011, nop=11001, halt=11010; any other opcode SHALL execute as nop.
REQ-010 SHALL perform fetch for every instruction: T0 PCout,MARin,IncPC; T1 Read,MDRin; T2 MDRout,IRin.
REQ-011 SHALL assert in T3 exactly: Grb,Rout,Yin for add/sub/and/or/addi; Grb,BAout,Yin for ld/ldi/st; Gra,Rout,CONin for br; Gra,Rout,PCin for jr; nothing for nop.
REQ-012 SHALL in T4 assert Grc,Rout,ZLowIn with alu_op=opcode for add/sub/and/or; RCout,ZLowIn with alu_op=00011 (ADD) for addi/ld/ldi/st; PCout,Yin for br.
REQ-013 SHALL in T5 assert ZLowOut,Gra,Rin for add/sub/and/or/addi/ldi; ZLowOut,MARin for ld/st; RCout,ZLowIn, alu_op=00011 for br.
REQ-014 SHALL in T6 assert Read,MDRin for ld; Gra,Rout,MDRin (Read low) for st; ZLowOut for br, plus PCin only when CON=1.
REQ-015 SHALL in T7 assert MDRout,Gra,Rin for ld and Write for st.
REQ-016 SHALL return to T0 after the last step: T3 for jr/nop, T5 for ALU/addi/ldi, T6 for br, T7 for ld/st.
REQ-017 SHALL on halt opcode go T3→HALT, assert no strobes, hold HALT until clear=0.
REQ-018 SHALL keep alu_op=00000 in every state/opcode pair not named in REQ-012/013.
REQ-019 SHALL never assert Read and Write together, nor two bus drivers (PCout, MDRout, ZLowOut, Rout, RCout) in the same state.
REQ-020 SHALL sample IR only in T3–T7; IR changes in T0–T2 SHALL not affect outputs.

Reset
REQ-021 SHALL, when clear=0 at a rising edge in any state including mid-instruction or HALT, enter RESET with all outputs 0 on the next cycle.
REQ-022 SHALL stay in RESET while clear=0 and move RESET→T0 on the first edge with clear=1; Run=1 from T0 onward.
REQ-023 SHALL not raise Write or PCin during or on the cycle after reset.

Verification
REQ-024 Bench SHALL check reset: clear=0 for 2 cycles mid-ld T6, then release -> RESET, all outputs 0, Run=0, next state T0 with PCout=MARin=IncPC=1.
REQ-025 Bench SHALL check add: IR=0x18A18000 (add) -> T3 Grb,Rout,Yin; T4 Grc,Rout,ZLowIn, alu_op=00011; T5 ZLowOut,Gra,Rin; T0 next.
REQ-026 Bench SHALL check ld: IR opcode 00000 -> T5 ZLowOut,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; 8 cycles total T0–T7.
REQ-027 Bench SHALL check br: opcode 10010 with CON=1 -> T6 ZLowOut,PCin=1; repeat with CON=0 -> T6 ZLowOut=1, PCin=0; both return to T0.
REQ-028 Bench SHALL check st: opcode 00010 -> T6 Gra,Rout,MDRin, Read=0; T7 Write=1 only; Read&Write never both high.
REQ-029 Bench SHALL check halt and unknown opcode: opcode 11010 -> HALT, Run=0, strobes 0 for 10 cycles until clear=0; opcode 11111 -> T3 no strobes, then T0.
